// File: rtl/simplecore_pkg.sv
// Shared constants for the simple core's tightly-coupled memories.
package simplecore_pkg;

  localparam logic [31:0] ItcmBaseAddr = 32'h0000_0000;
  localparam logic [31:0] DtcmBaseAddr = 32'h8000_0000;
  localparam int unsigned TcmDataWidth = 32;
  // Response payload is {err, rdata}.
  localparam int unsigned TcmRspWidth  = TcmDataWidth + 1;

endpackage

// File: rtl/tcm_ctrl_if.sv
// Command/response valid-ready bus between the core and the TCM controller.
interface tcm_ctrl_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned MW = DW / 8
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/tcm_rsp_skid.sv
// One-entry response skid buffer; a held entry always takes priority over the input.
module tcm_rsp_skid
  import simplecore_pkg::*;
#(
  parameter int unsigned Width = TcmRspWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  input  logic             ready,
  output logic             out_valid,
  output logic [Width-1:0] out_data,
  output logic             full
);

  logic             skid_v_q, skid_v_d;
  logic [Width-1:0] skid_data_q, skid_data_d;

  assign out_valid = skid_v_q | in_valid;
  assign out_data  = skid_v_q ? skid_data_q : in_data;
  assign full      = skid_v_q;

  always_comb begin
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (!skid_v_q) begin
      // Capture the input only when it is offered but not taken.
      skid_v_d    = in_valid & ~ready;
      skid_data_d = in_data;
    end else if (ready) begin
      skid_v_d    = in_valid;
      skid_data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: rtl/tcm_ctrl.sv
// Byte-addressed valid/ready front end for the single-port TCM SRAM, one command per cycle.
module tcm_ctrl
  import simplecore_pkg::*;
#(
  parameter int unsigned   DP        = 512,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   MW        = DW / 8,
  parameter int unsigned   AW        = 32,
  parameter int unsigned   RAW       = $clog2(DP),
  parameter logic [AW-1:0] BASE_ADDR = DtcmBaseAddr
) (
  input  logic            clk,
  input  logic            rst,
  tcm_ctrl_if.slave       bus,
  output logic [RAW-1:0]  ram_addr,
  output logic            ram_we,
  output logic [MW-1:0]   ram_wem,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  localparam int unsigned RspW = DW + 1;

  logic [AW-1:0]  off;
  logic           err;
  logic           accept;
  logic           skid_full;
  logic [RAW-1:0] cmd_idx;

  logic           p1_v_q, p1_v_d;
  logic           p1_read_q, p1_read_d;
  logic           p1_err_q, p1_err_d;
  logic [RAW-1:0] p1_idx_q, p1_idx_d;

  logic [RspW-1:0] p1_rsp;
  logic [RspW-1:0] out_rsp;

  assign off     = bus.cmd_addr - BASE_ADDR;
  assign err     = (bus.cmd_addr < BASE_ADDR) | (off >= AW'(DP * 4)) | (off[1:0] != 2'b00);
  assign cmd_idx = off[RAW+1:2];

  assign bus.cmd_ready = ~skid_full & ~rst;
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  // Idle cycles re-read the pending P1 word so ram_dout stays stable under stall.
  always_comb begin
    ram_we   = 1'b0;
    ram_wem  = '0;
    ram_din  = '0;
    ram_addr = p1_idx_q;
    if (accept && !err) begin
      ram_addr = cmd_idx;
      if (!bus.cmd_read) begin
        ram_we  = 1'b1;
        ram_wem = bus.cmd_wmask;
        ram_din = bus.cmd_wdata;
      end
    end
  end

  always_comb begin
    p1_v_d    = p1_v_q & skid_full & ~bus.rsp_ready;
    p1_read_d = p1_read_q;
    p1_err_d  = p1_err_q;
    p1_idx_d  = p1_idx_q;
    if (accept) begin
      p1_v_d    = 1'b1;
      p1_read_d = bus.cmd_read;
      p1_err_d  = err;
      p1_idx_d  = cmd_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_v_q    <= 1'b0;
      p1_read_q <= 1'b0;
      p1_err_q  <= 1'b0;
      p1_idx_q  <= '0;
    end else begin
      p1_v_q    <= p1_v_d;
      p1_read_q <= p1_read_d;
      p1_err_q  <= p1_err_d;
      p1_idx_q  <= p1_idx_d;
    end
  end

  assign p1_rsp = {p1_v_q & p1_err_q,
                   (p1_v_q & p1_read_q & ~p1_err_q) ? ram_dout : {DW{1'b0}}};

  tcm_rsp_skid #(
    .Width (RspW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (p1_v_q),
    .in_data   (p1_rsp),
    .ready     (bus.rsp_ready),
    .out_valid (bus.rsp_valid),
    .out_data  (out_rsp),
    .full      (skid_full)
  );

  assign bus.rsp_err   = out_rsp[DW];
  assign bus.rsp_rdata = out_rsp[DW-1:0];

endmodule

// File: tb/tb_tcm_ctrl.sv
// Directed bench for tcm_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_tcm_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] OOR  = 32'h8000_0800;  // BASE + DP*4

  logic        clk;
  logic        rst;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  int errors = 0;
  int checks = 0;

  tcm_ctrl_if #(.AW(32), .DW(32), .MW(4)) bus ();

  tcm_ctrl #(
    .DP        (512),
    .DW        (32),
    .MW        (4),
    .AW        (32),
    .RAW       (9),
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wem  (ram_wem),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  logic [31:0] mem [512];

  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end
    end
    ram_dout <= mem[ram_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic rr, input logic rd, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    bus.rsp_ready = rr;
    bus.cmd_valid = 1'b1;
    bus.cmd_read  = rd;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_wmask = m;
    #1;
  endtask

  task automatic idle(input logic rr);
    @(negedge clk);
    bus.rsp_ready = rr;
    bus.cmd_valid = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  logic [31:0] ref_mem [4];
  logic [31:0] rnd, wd, prev_exp;
  logic        rd;
  logic [1:0]  w;
  logic [3:0]  wm;

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_read  = 1'b1;
    bus.cmd_addr  = BASE;
    bus.cmd_wdata = '0;
    bus.cmd_wmask = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
    end
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);

    @(negedge clk);
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rel_rsp_valid", 32'(bus.rsp_valid), 0);

    // Full write then read-after-write, then byte-masked overwrite.
    cmd(1, 0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    chk("wr_ram_we", 32'(ram_we), 1);
    chk("wr_ram_addr", 32'(ram_addr), 4);
    chk("wr_ram_wem", 32'(ram_wem), 32'hF);
    chk("wr_ram_din", ram_din, 32'hDEAD_BEEF);
    cmd(1, 1, BASE + 32'h10, 0, 0);
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("wr_rsp_err", 32'(bus.rsp_err), 0);
    chk("wr_rsp_rdata", bus.rsp_rdata, 0);
    chk("rd_ram_we", 32'(ram_we), 0);
    chk("rd_ram_addr", 32'(ram_addr), 4);
    cmd(1, 0, BASE + 32'h10, 32'h1122_3344, 4'b0101);
    chk("raw_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    chk("raw_valid", 32'(bus.rsp_valid), 1);
    chk("mask_ram_wem", 32'(ram_wem), 32'h5);
    cmd(1, 1, BASE + 32'h10, 0, 0);
    chk("mwr_rsp_rdata", bus.rsp_rdata, 0);

    // Out-of-range and misaligned reads.
    cmd(1, 1, OOR, 0, 0);
    chk("mask_rdata", bus.rsp_rdata, 32'hDE22_BE44);
    chk("oor_ram_we", 32'(ram_we), 0);
    chk("oor_ram_addr_held", 32'(ram_addr), 4);
    cmd(1, 1, BASE + 32'h2, 0, 0);
    chk("oor_rsp_err", 32'(bus.rsp_err), 1);
    chk("oor_rsp_rdata", bus.rsp_rdata, 0);
    chk("mis_ram_we", 32'(ram_we), 0);
    idle(1);
    chk("mis_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("mis_rsp_err", 32'(bus.rsp_err), 1);
    chk("mis_rsp_rdata", bus.rsp_rdata, 0);

    for (int i = 0; i < 4; i++) cmd(1, 0, BASE + 32'(4 * i), 32'(i), 4'hF);
    idle(1);

    // Back-pressure: two accepts fill P1 and the skid entry.
    cmd(0, 1, BASE + 32'h0, 0, 0);
    chk("bp_ready0", 32'(bus.cmd_ready), 1);
    cmd(0, 1, BASE + 32'h4, 0, 0);
    chk("bp_ready1", 32'(bus.cmd_ready), 1);
    chk("bp_valid1", 32'(bus.rsp_valid), 1);
    chk("bp_rdata1", bus.rsp_rdata, 0);
    cmd(0, 1, BASE + 32'h8, 0, 0);
    chk("bp_ready2", 32'(bus.cmd_ready), 0);
    chk("bp_hold_rdata", bus.rsp_rdata, 0);
    chk("bp_hold_valid", 32'(bus.rsp_valid), 1);
    cmd(1, 1, BASE + 32'h8, 0, 0);
    chk("bp_ready3", 32'(bus.cmd_ready), 0);
    chk("bp_rsp_a", bus.rsp_rdata, 0);
    cmd(1, 1, BASE + 32'h8, 0, 0);
    chk("bp_ready4", 32'(bus.cmd_ready), 0);
    chk("bp_rsp_b_valid", 32'(bus.rsp_valid), 1);
    chk("bp_rsp_b", bus.rsp_rdata, 1);
    cmd(1, 1, BASE + 32'h8, 0, 0);
    chk("bp_ready5", 32'(bus.cmd_ready), 1);
    chk("bp_gap_valid", 32'(bus.rsp_valid), 0);
    cmd(1, 1, BASE + 32'hC, 0, 0);
    chk("bp_rsp_c", bus.rsp_rdata, 2);
    idle(1);
    chk("bp_rsp_d", bus.rsp_rdata, 3);
    idle(1);
    chk("bp_drained", 32'(bus.rsp_valid), 0);

    // Zero-mask write and out-of-range write leave memory unchanged.
    cmd(1, 0, BASE + 32'h4, 32'hFFFF_FFFF, 4'h0);
    chk("m0_ram_we", 32'(ram_we), 1);
    chk("m0_ram_wem", 32'(ram_wem), 0);
    cmd(1, 0, OOR, 32'hCAFE_F00D, 4'hF);
    chk("m0_rsp_err", 32'(bus.rsp_err), 0);
    chk("m0_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("oorw_ram_we", 32'(ram_we), 0);
    cmd(1, 1, BASE + 32'h4, 0, 0);
    chk("oorw_rsp_err", 32'(bus.rsp_err), 1);
    chk("oorw_rsp_rdata", bus.rsp_rdata, 0);
    cmd(1, 1, BASE + 32'h0, 0, 0);
    chk("m0_readback", bus.rsp_rdata, 1);
    chk("m0_readback_err", 32'(bus.rsp_err), 0);
    idle(1);
    chk("oorw_readback", bus.rsp_rdata, 0);

    // Reset with both P1 and skid occupied drops the pending responses.
    cmd(0, 1, BASE + 32'h8, 0, 0);
    cmd(0, 1, BASE + 32'hC, 0, 0);
    @(negedge clk);
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    #1;
    chk("mrst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("mrst_pre_valid", 32'(bus.rsp_valid), 1);
    @(negedge clk);
    rst           = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("mrst_dropped", 32'(bus.rsp_valid), 0);
    chk("mrst_cmd_ready_rel", 32'(bus.cmd_ready), 1);

    // Streaming over words 0..3 against a reference array.
    ref_mem[0] = 32'd0;
    ref_mem[1] = 32'd1;
    ref_mem[2] = 32'd2;
    ref_mem[3] = 32'd3;
    prev_exp   = '0;
    for (int i = 0; i < 64; i++) begin
      rnd = $urandom;
      wd  = $urandom;
      rd  = rnd[0];
      w   = rnd[2:1];
      wm  = rnd[6:3];
      cmd(1, rd, BASE + {28'd0, w, 2'b00}, wd, wm);
      chk("st_cmd_ready", 32'(bus.cmd_ready), 1);
      if (i > 0) begin
        chk("st_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("st_rsp_rdata", bus.rsp_rdata, prev_exp);
        chk("st_rsp_err", 32'(bus.rsp_err), 0);
      end
      if (rd) begin
        prev_exp = ref_mem[w];
      end else begin
        prev_exp   = '0;
        ref_mem[w] = merge(ref_mem[w], wd, wm);
      end
    end
    idle(1);
    chk("st_last_valid", 32'(bus.rsp_valid), 1);
    chk("st_last_rdata", bus.rsp_rdata, prev_exp);
    for (int k = 0; k < 4; k++) begin
      cmd(1, 1, BASE + 32'(4 * k), 0, 0);
      idle(1);
      chk("st_final_word", bus.rsp_rdata, ref_mem[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tcm_ctrl.md
# tcm_ctrl

Bus-side controller sitting directly upstream of the single-port TCM SRAM model. It accepts byte-addressed valid/ready commands from the core's load/store or fetch path and converts them into word-indexed SRAM accesses. It returns in-order responses through a valid/ready channel and absorbs response back-pressure with a one-entry skid buffer. The SRAM's 1-cycle read latency is hidden so that sustained throughput is one command per cycle.

## Interface
- DP, 512: SRAM depth in words
- DW, 32: data width
- MW, 4: byte-mask width (DW/8)
- AW, 32: command address width (byte address)
- RAW, clog2(DP): SRAM word-address width
- BASE_ADDR, 32'h8000_0000: byte address mapped to SRAM word 0
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_read  in  1  1 = read, 0 = write
- cmd_addr  in  AW  byte address
- cmd_wdata  in  DW  write data
- cmd_wmask  in  MW  byte-lane write enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  DW  read data (0 for writes and errors)
- rsp_err  out  1  address out of range or misaligned
- ram_addr  out  RAW  SRAM word address
- ram_we  out  1  SRAM write enable (0 = read cycle)
- ram_wem  out  MW  SRAM byte mask
- ram_din  out  DW  SRAM write data
- ram_dout  in  DW  SRAM read data, valid the cycle after a read cycle

## Operation
- Decode: off = cmd_addr − BASE_ADDR; err = (cmd_addr < BASE_ADDR) | (off ≥ DP*4) | (off[1:0] ≠ 0); word index = off[RAW+1:2].
- Accept (cmd_valid & cmd_ready):
  - Non-error write: ram_we=1, ram_wem=cmd_wmask, ram_din=cmd_wdata, ram_addr=index.
  - Non-error read: ram_we=0, ram_addr=index.
  - Error: ram_we=0 and ram_addr=held address, so there is no SRAM side effect.
- A write with wmask=0 still produces a normal response with err=0 and leaves memory unchanged.
- Pipeline stage P1 is loaded on accept with {read, err, index}. p1_v is set for one cycle unless the response stalls.
- Response source priority:
  1. Skid entry, if present.
  2. Otherwise P1.
- P1 response payload: rdata = (read & ~err) ? ram_dout : 0; err = p1_err.
- Stall handling: if P1 is valid and not consumed in a cycle, its payload (including ram_dout) moves into the skid entry at the next edge.
- Skid-entry drain: when the skid entry is consumed and P1 is also valid, P1 moves into the skid entry.
- cmd_ready = ~skid_v & ~rst. This allows at most 2 responses outstanding (skid + P1).
- Hold rule: whenever no command is accepted, drive ram_we=0 and ram_addr=p1_index. The SRAM re-registers the same address, so ram_dout stays stable for the pending P1 read.
- Responses are returned strictly in command order.

## Timing
- Reset values: rsp_valid=0, rsp_err=0, rsp_rdata=0, cmd_ready=0 while rst=1; ram_we=0, ram_wem=0, ram_addr=0, p1_v=0, skid_v=0.
- cmd_ready=1 in the first cycle after rst deasserts.
- Latency: a command accepted in cycle N gives rsp_valid in cycle N+1 if the skid entry is empty.
- Throughput: with rsp_ready held at 1, back-to-back commands are accepted every cycle.
- rsp_ready low at N+1 with a new accept at N+1:
  - N+2: skid holds response A; P1 holds B; cmd_ready=0.
  - A is sent first, then B.
- Read-after-write to the same word in consecutive cycles returns the new data, because the SRAM write completes at the edge ending the write cycle.
- Reset asserted mid-operation drops all pending responses at the next edge. SRAM contents are not touched.
- Payload stability: rsp_valid, rsp_rdata and rsp_err stay stable while rsp_valid & ~rsp_ready.

## Structure
- Shared package simplecore_pkg holds:
  - the TCM base-address constants for ITCM and DTCM;
  - the response-payload width constant (DW+1).
- Sub-module tcm_rsp_skid implements the one-entry skid buffer: inputs in_valid/in_data; outputs out_valid/out_data; ready. tcm_ctrl instantiates it once.

## Test plan
- Reset: hold rst for 3 cycles with cmd_valid=1 → cmd_ready=0, rsp_valid=0, ram_we=0 throughout; cmd_ready=1 in the cycle after release.
- Write 0xDEADBEEF, mask 4'b1111 to BASE+0x10, then read BASE+0x10 next cycle → write response err=0 rdata=0; read response rdata=0xDEADBEEF one cycle later.
- Byte-mask write 0x11223344 with mask 4'b0101 over 0xDEADBEEF at BASE+0x10, then read → rdata=0xDE22BE44.
- Out-of-range read at BASE+DP*4 and misaligned read at BASE+0x2 → each gives rsp_err=1, rdata=0, ram_we=0.
- Out-of-range write → rsp_err=1 and memory unchanged on readback.
- Back-pressure: issue 4 reads (words 0..3 holding 0..3) with rsp_ready=0 for 3 cycles → cmd_ready drops after 2 accepts; responses 0,1,2,3 arrive in order, with no loss or duplication once rsp_ready=1.
- Streaming: 64 random reads/writes with rsp_ready=1 → one accept per cycle; every rsp matches a reference word-array model.
